song_sequencer: RTL and testbench
=================================

# song_sequencer

Parametrised successor to the single-song note reader. Steps through a note ROM holding 2^SONG_W songs of up to 2^IDX_W notes each. For each note it issues a {note, duration} pair to the note player with a one-cycle `new_note` strobe, then waits for `note_done`. Adds three behaviours the previous reader lacked: early end-of-song markers, loop mode, and song switching at note boundaries. Sits between the user-control logic and the note player.

## Interface
- SONG_W, 2, song select width; 2^SONG_W songs
- IDX_W, 5, note index width; max 2^IDX_W notes per song
- NOTE_W, 6, note code width
- DUR_W, 6, duration width; duration 0 is the end-of-song marker

- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- play  in  1  level; high = run, low = pause at next note boundary
- loop  in  1  level; sampled at end of song; high = restart song from index 0
- song  in  SONG_W  song select; latched on start, checked at each note boundary
- note_done  in  1  one-cycle pulse from note player; only honoured in WAIT
- note  out  NOTE_W  current note code, registered, held until next new_note
- duration  out  DUR_W  current duration, registered, held until next new_note
- new_note  out  1  one-cycle strobe; note/duration valid in the same cycle
- song_done  out  1  one-cycle strobe at end of song
- busy  out  1  high in every state except IDLE and DONE

## Operation
- ROM word = {note[NOTE_W-1:0], duration[DUR_W-1:0]}. ROM address = {song_q, idx}.
- States:
  - IDLE: idx=0. When play=1, latch song_q<=song and go to FETCH.
  - FETCH: drive address and go to LOAD.
  - LOAD: ROM data valid.
    - If duration==0: end of song; treat as END.
    - Else register note/duration, assert new_note the next cycle, and go to WAIT.
  - WAIT: hold until note_done=1, then evaluate in this priority order:
    1. idx==2^IDX_W-1: END.
    2. song!=song_q: song_q<=song, idx<=0, go to FETCH if play else PAUSE. No song_done.
    3. Otherwise idx<=idx+1, go to FETCH if play else PAUSE.
  - PAUSE: idx held. When play=1, go to FETCH. A song change seen on PAUSE exit also restarts at idx 0.
  - END action: pulse song_done for one cycle and set idx<=0.
    - If loop=1 and play=1: go to FETCH.
    - Else go to DONE.
  - DONE: hold until play=0, then go to IDLE. This blocks auto-replay while play stays high.
- Deasserting play during WAIT does not cut the current note. The pause takes effect at note_done.
- note_done outside WAIT is ignored. It is not queued.
- idx never wraps silently. The last slot always ends the song even when duration!=0.

## Timing
- Reset (async, reset_n=0):
  - state=IDLE, idx=0, song_q=0
  - note=0, duration=0, new_note=0, song_done=0, busy=0
- play sampled high in IDLE at edge T: FETCH at T+1, LOAD at T+2, new_note=1 with valid note/duration at T+3.
- note_done sampled at edge T in WAIT: next new_note at T+3. The player sees a 2-cycle gap with no strobe.
- A note_done in the same cycle as new_note is accepted.
- End-of-song:
  - song_done asserts at the cycle after the terminating LOAD (marker) or after the terminating WAIT (last slot).
  - With loop, the first note of the restart follows song_done by 2 cycles.
- reset_n low mid-note: all outputs clear immediately (asynchronously). The ROM output register clears too.

## Structure
- Package song_seq_pkg holds:
  - state enum {IDLE, FETCH, LOAD, WAIT, PAUSE, DONE}
  - localparam WORD_W = NOTE_W+DUR_W
  - END_MARK duration constant 0
- Sub-module song_rom: synchronous read, 1-cycle latency, depth 2^(SONG_W+IDX_W), width WORD_W, init from file parameter.
- Top holds the FSM, idx counter, song_q latch and output registers.

## Test plan
- Reset, song=0, play=1, ROM song 0 = three notes then duration 0 -> new_note at cycle 3 with first {note,duration}. Three strobes total. song_done one cycle after the marker LOAD. DONE with busy=0.
- play=0 during note 2, then note_done -> PAUSE, no new_note. Set play=1 -> note 3 issued 3 cycles later, idx continues at 2.
- loop=1, song 1 of two notes + marker -> song_done, then note 0 of song 1 reissued 2 cycles later, repeating with no IDLE visit.
- song changed 0->2 mid note 1, then note_done -> next strobe carries song 2 index 0 data. No song_done.
- Full song of 2^IDX_W=32 nonzero notes -> song_done after note_done of note 31. idx returns to 0.
- reset_n pulsed low while in WAIT -> note, duration and busy read 0 before the next clk edge. IDLE after release.

Source files
------------

// File: rtl/song_seq_pkg.sv
// Shared types and default widths for the song sequencer and its note ROM.
package song_seq_pkg;

   localparam int DEF_SONG_W = 2;
   localparam int DEF_IDX_W  = 5;
   localparam int DEF_NOTE_W = 6;
   localparam int DEF_DUR_W  = 6;
   localparam int WORD_W     = DEF_NOTE_W + DEF_DUR_W;

   // A zero duration in a ROM word terminates the song early.
   localparam int END_MARK   = 0;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LOAD,
      WAIT,
      PAUSE,
      DONE
   } state_t;

   function automatic logic is_busy(state_t s);
      return (s != IDLE) && (s != DONE);
   endfunction

endpackage

// File: rtl/song_sequencer_if.sv
// Control/player-side signals of the sequencer; master is the sequencer itself.
interface song_sequencer_if #(
   parameter int SONG_W = 2,
   parameter int NOTE_W = 6,
   parameter int DUR_W  = 6
);
   logic              play;
   logic              loop;
   logic [SONG_W-1:0] song;
   logic              note_done;
   logic [NOTE_W-1:0] note;
   logic [DUR_W-1:0]  duration;
   logic              new_note;
   logic              song_done;
   logic              busy;

   modport master (
      input  play, loop, song, note_done,
      output note, duration, new_note, song_done, busy
   );

   modport slave (
      output play, loop, song, note_done,
      input  note, duration, new_note, song_done, busy
   );
endinterface

// File: rtl/song_rom.sv
// Note ROM with a registered read port; contents come from a flattened image
// parameter (word a at bits [a*DATA_W +: DATA_W]) generated from the song file.
module song_rom
   import song_seq_pkg::*;
#(
   parameter int ADDR_W = DEF_SONG_W + DEF_IDX_W,
   parameter int DATA_W = WORD_W,
   parameter logic [(2**ADDR_W)*DATA_W-1:0] INIT = '0
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [ADDR_W-1:0] addr_i,
   output logic [DATA_W-1:0] data_o
);

   localparam int DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] data_q;

   for (genvar a = 0; a < DEPTH; a++) begin : g_mem
      assign mem[a] = INIT[a*DATA_W +: DATA_W];
   end

   // The read register clears with reset so a stale word never reaches LOAD.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         data_q <= '0;
      end else begin
         data_q <= mem[addr_i];
      end
   end

   assign data_o = data_q;

endmodule

// File: rtl/song_sequencer.sv
// Walks one song of the note ROM, handing {note, duration} pairs to the note
// player; handles end markers, looping, pausing and song switching at note boundaries.
module song_sequencer
   import song_seq_pkg::*;
#(
   parameter int SONG_W = DEF_SONG_W,
   parameter int IDX_W  = DEF_IDX_W,
   parameter int NOTE_W = DEF_NOTE_W,
   parameter int DUR_W  = DEF_DUR_W,
   parameter logic [(2**(SONG_W+IDX_W))*(NOTE_W+DUR_W)-1:0] ROM_INIT = '0
) (
   input  logic              clk,
   input  logic              reset_n,
   song_sequencer_if.master  seq_if
);

   localparam int ADDR_W = SONG_W + IDX_W;
   localparam int ROM_W  = NOTE_W + DUR_W;
   localparam logic [IDX_W-1:0] IDX_LAST = '1;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [SONG_W-1:0] song_q, song_d;
   logic [NOTE_W-1:0] note_q, note_d;
   logic [DUR_W-1:0]  dur_q, dur_d;
   logic              new_note_q, new_note_d;
   logic              song_done_q, song_done_d;
   logic              end_song;

   logic [ROM_W-1:0]  rom_data;
   logic [NOTE_W-1:0] rom_note;
   logic [DUR_W-1:0]  rom_dur;

   song_rom #(
      .ADDR_W (ADDR_W),
      .DATA_W (ROM_W),
      .INIT   (ROM_INIT)
   ) u_rom (
      .clk_i  (clk),
      .rst_ni (reset_n),
      .addr_i ({song_q, idx_q}),
      .data_o (rom_data)
   );

   assign {rom_note, rom_dur} = rom_data;

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      song_d      = song_q;
      note_d      = note_q;
      dur_d       = dur_q;
      new_note_d  = 1'b0;
      song_done_d = 1'b0;
      end_song    = 1'b0;

      unique case (state_q)
         IDLE: begin
            idx_d = '0;
            if (seq_if.play) begin
               song_d  = seq_if.song;
               state_d = FETCH;
            end
         end
         FETCH: state_d = LOAD;
         LOAD: begin
            if (rom_dur == DUR_W'(END_MARK)) begin
               end_song = 1'b1;
            end else begin
               note_d     = rom_note;
               dur_d      = rom_dur;
               new_note_d = 1'b1;
               state_d    = WAIT;
            end
         end
         WAIT: begin
            if (seq_if.note_done) begin
               // The last slot ends the song even if a switch is pending.
               if (idx_q == IDX_LAST) begin
                  end_song = 1'b1;
               end else begin
                  if (seq_if.song != song_q) begin
                     song_d = seq_if.song;
                     idx_d  = '0;
                  end else begin
                     idx_d  = idx_q + 1'b1;
                  end
                  state_d = seq_if.play ? FETCH : PAUSE;
               end
            end
         end
         PAUSE: begin
            if (seq_if.play) begin
               if (seq_if.song != song_q) begin
                  song_d = seq_if.song;
                  idx_d  = '0;
               end
               state_d = FETCH;
            end
         end
         DONE: begin
            // Waiting for play to drop stops a held play level from replaying.
            if (!seq_if.play) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (end_song) begin
         song_done_d = 1'b1;
         idx_d       = '0;
         state_d     = (seq_if.loop && seq_if.play) ? FETCH : DONE;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         song_q      <= '0;
         note_q      <= '0;
         dur_q       <= '0;
         new_note_q  <= 1'b0;
         song_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         song_q      <= song_d;
         note_q      <= note_d;
         dur_q       <= dur_d;
         new_note_q  <= new_note_d;
         song_done_q <= song_done_d;
      end
   end

   assign seq_if.note      = note_q;
   assign seq_if.duration  = dur_q;
   assign seq_if.new_note  = new_note_q;
   assign seq_if.song_done = song_done_q;
   assign seq_if.busy      = is_busy(state_q);

endmodule

// File: tb/tb_song_sequencer.sv
// Randomised-timing bench for song_sequencer: a bench-side song table and a
// traversal/latency model predict every strobe, its data and the song_done cycle.
module tb_song_sequencer;

   localparam int SW    = 2;
   localparam int IW    = 5;
   localparam int NW    = 6;
   localparam int DW    = 6;
   localparam int WW    = NW + DW;
   localparam int NSONG = 4;
   localparam int NIDX  = 32;
   localparam int BITS  = NSONG * NIDX * WW;

   // Song table: song 0 has 3 notes, song 1 has 2, song 2 has 5, song 3 fills all 32 slots.
   function automatic int f_dur(int s, int i);
      if ((s == 0 && i >= 3) || (s == 1 && i >= 2) || (s == 2 && i >= 5)) return 0;
      return 1 + (s * 13 + i * 5) % 63;
   endfunction

   function automatic int f_note(int s, int i);
      return (s * 23 + i * 7 + 3) % 64;
   endfunction

   function automatic logic [BITS-1:0] f_image();
      logic [BITS-1:0] img;
      img = '0;
      for (int s = 0; s < NSONG; s++)
         for (int i = 0; i < NIDX; i++)
            img[(s * NIDX + i) * WW +: WW] = {NW'(f_note(s, i)), DW'(f_dur(s, i))};
      return img;
   endfunction

   // note_done driven in cycle k: the final slot ends at the next edge; a marker
   // needs a further fetch and load of the marker word.
   function automatic int end_gap(int i);
      return (i == NIDX - 1) ? 1 : 3;
   endfunction

   localparam logic [BITS-1:0] IMG = f_image();

   logic clk = 1'b0;
   logic reset_n;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_err = 0;
   int   n_strobe = 0;
   int   n_done = 0;
   int   exp_cyc = 0;
   int   done_cyc = 0;

   song_sequencer_if #(.SONG_W(SW), .NOTE_W(NW), .DUR_W(DW)) bus ();

   song_sequencer #(
      .SONG_W   (SW),
      .IDX_W    (IW),
      .NOTE_W   (NW),
      .DUR_W    (DW),
      .ROM_INIT (IMG)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .seq_if  (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #2;
      if (bus.new_note)  n_strobe++;
      if (bus.song_done) n_done++;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0d exp=%0d (cyc %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic wait_strobe(input string tag);
      int n = 0;
      while (!bus.new_note && n < 20) begin
         tick();
         n++;
      end
      chk({tag, ".seen"}, int'(bus.new_note), 1);
   endtask

   task automatic wait_done(input string tag, input int expc);
      int n = 0;
      while (!bus.song_done && n < 20) begin
         tick();
         n++;
      end
      chk({tag, ".done_seen"}, int'(bus.song_done), 1);
      chk({tag, ".done_cyc"}, cyc, expc);
      done_cyc = cyc;
   endtask

   // Play one note as the player would: check the strobe, optionally drop play or
   // retarget the song mid-note, then pulse note_done after d cycles.
   task automatic serve_note(input string tag, input int s, input int i, input int d,
                             input bit drop, input int nsong, output int kd);
      wait_strobe(tag);
      chk({tag, ".cyc"}, cyc, exp_cyc);
      chk({tag, ".note"}, int'(bus.note), f_note(s, i));
      chk({tag, ".dur"}, int'(bus.duration), f_dur(s, i));
      if (drop) bus.play = 1'b0;
      bus.song = SW'(nsong);
      repeat (d) tick();
      bus.note_done = 1'b1;
      kd = cyc;
      tick();
      bus.note_done = 1'b0;
   endtask

   task automatic start(input int s, input bit lp);
      bus.song = SW'(s);
      bus.loop = lp;
      bus.play = 1'b1;
      exp_cyc  = cyc + 3;
   endtask

   task automatic to_idle();
      bus.play = 1'b0;
      repeat (3) tick();
   endtask

   initial begin
      int kd, s0, d0, w;
      reset_n       = 1'b0;
      bus.play      = 1'b0;
      bus.loop      = 1'b0;
      bus.song      = '0;
      bus.note_done = 1'b0;
      tick();
      tick();
      chk("rst.note", int'(bus.note), 0);
      chk("rst.dur", int'(bus.duration), 0);
      chk("rst.new_note", int'(bus.new_note), 0);
      chk("rst.song_done", int'(bus.song_done), 0);
      chk("rst.busy", int'(bus.busy), 0);
      reset_n = 1'b1;
      repeat (2) tick();

      // Three notes then a marker; a stray note_done before the first note is ignored.
      s0 = n_strobe;
      d0 = n_done;
      start(0, 1'b0);
      tick();
      bus.note_done = 1'b1;
      tick();
      bus.note_done = 1'b0;
      for (int i = 0; i < 3; i++) begin
         serve_note("A", 0, i, $urandom_range(3, 0), 1'b0, 0, kd);
         exp_cyc = kd + 3;
      end
      wait_done("A", kd + end_gap(2));
      tick();
      chk("A.busy_done", int'(bus.busy), 0);
      repeat (4) tick();
      chk("A.strobes", n_strobe - s0, 3);
      chk("A.dones", n_done - d0, 1);
      chk("A.no_replay", int'(bus.busy), 0);
      to_idle();

      // Pause after note 1, resume a random time later at note 2.
      start(0, 1'b0);
      serve_note("B", 0, 0, $urandom_range(3, 0), 1'b0, 0, kd);
      exp_cyc = kd + 3;
      serve_note("B", 0, 1, $urandom_range(3, 0), 1'b1, 0, kd);
      s0 = n_strobe;
      w  = $urandom_range(6, 2);
      repeat (w) tick();
      chk("B.paused_strobes", n_strobe - s0, 0);
      chk("B.paused_busy", int'(bus.busy), 1);
      bus.play = 1'b1;
      exp_cyc  = cyc + 3;
      serve_note("B", 0, 2, $urandom_range(3, 0), 1'b0, 0, kd);
      wait_done("B", kd + end_gap(2));
      to_idle();

      // Loop song 1 twice without passing through IDLE, then let it stop.
      s0 = n_strobe;
      start(1, 1'b1);
      for (int pass = 0; pass < 2; pass++) begin
         if (pass == 1) bus.loop = 1'b0;
         serve_note("C", 1, 0, $urandom_range(3, 0), 1'b0, 1, kd);
         exp_cyc = kd + 3;
         serve_note("C", 1, 1, $urandom_range(3, 0), 1'b0, 1, kd);
         wait_done("C", kd + end_gap(1));
         chk("C.busy_at_done", int'(bus.busy), 1 - pass);
         exp_cyc = done_cyc + 2;
      end
      repeat (3) tick();
      chk("C.strobes", n_strobe - s0, 4);
      to_idle();

      // Switch to song 2 during note 1: restart at song 2 index 0, no song_done.
      start(0, 1'b0);
      serve_note("D", 0, 0, $urandom_range(3, 0), 1'b0, 0, kd);
      exp_cyc = kd + 3;
      d0 = n_done;
      serve_note("D", 0, 1, $urandom_range(3, 0), 1'b0, 2, kd);
      exp_cyc = kd + 3;
      for (int i = 0; i < 5; i++) begin
         serve_note("D", 2, i, $urandom_range(3, 0), 1'b0, 2, kd);
         exp_cyc = kd + 3;
         if (i == 0) chk("D.no_done", n_done - d0, 0);
      end
      wait_done("D", kd + end_gap(4));
      to_idle();

      // All 32 slots of song 3; the last slot ends the song and the loop restarts at 0.
      start(3, 1'b1);
      for (int i = 0; i < NIDX; i++) begin
         serve_note("E", 3, i, $urandom_range(1, 0), 1'b0, 3, kd);
         exp_cyc = kd + 3;
      end
      wait_done("E", kd + end_gap(NIDX - 1));
      exp_cyc = done_cyc + 2;
      wait_strobe("E.restart");
      chk("E.restart_cyc", cyc, exp_cyc);
      chk("E.restart_note", int'(bus.note), f_note(3, 0));
      chk("E.restart_dur", int'(bus.duration), f_dur(3, 0));

      // Asynchronous reset in WAIT clears outputs before the next clock edge.
      tick();
      chk("F.busy_before", int'(bus.busy), 1);
      reset_n  = 1'b0;
      bus.play = 1'b0;
      bus.loop = 1'b0;
      #1;
      chk("F.note", int'(bus.note), 0);
      chk("F.dur", int'(bus.duration), 0);
      chk("F.busy", int'(bus.busy), 0);
      chk("F.new_note", int'(bus.new_note), 0);
      tick();
      reset_n = 1'b1;
      s0 = n_strobe;
      repeat (4) tick();
      chk("F.idle_busy", int'(bus.busy), 0);
      chk("F.idle_strobes", n_strobe - s0, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
